// File: rtl/ei_axi4_slave_mem_if.sv
// AXI4 slave-port bundle for ei_axi4_slave_mem: all five channels' handshake and payload signals.
interface ei_axi4_slave_mem_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave memory: independent write and read FSMs, one burst in flight each, FIXED/INCR/WRAP bursts,
// SLVERR for bad configurations or out-of-range beats while still completing every handshake.
module ei_axi4_slave_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input logic                aclk,
  input logic                aresetn,
  ei_axi4_slave_mem_if.slave axi
);
  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned BYTE_SH = $clog2(STRB_W);
  localparam int unsigned IDX_W   = $clog2(MEM_DEPTH);
  localparam int unsigned AW1     = ADDR_WIDTH + 1;
  localparam logic [1:0] B_INCR = 2'b01;
  localparam logic [1:0] B_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] n, t, lower, nxt;
    n     = ADDR_WIDTH'(1) << size;
    t     = ADDR_WIDTH'(9'(len) + 9'd1) * n;
    lower = a & ~(t - ADDR_WIDTH'(1));
    case (burst)
      B_INCR:  nxt = (a & ~(n - ADDR_WIDTH'(1))) + n;
      B_WRAP: begin
        nxt = a + n;
        if (nxt >= lower + t) nxt = lower;
      end
      default: nxt = a;
    endcase
    return nxt;
  endfunction

  // Burst-wide configuration errors, evaluated once at the address handshake.
  function automatic logic cfg_err(input logic [ADDR_WIDTH-1:0] a,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [AW1-1:0] n, first, last;
    logic           err;
    err   = 1'b0;
    n     = AW1'(1) << size;
    first = AW1'(a) & ~(n - AW1'(1));
    last  = first + AW1'(9'(len) + 9'd1) * n - AW1'(1);
    if (32'(size) > BYTE_SH) err = 1'b1;
    if (burst == 2'b11) err = 1'b1;
    if (burst == B_WRAP && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) err = 1'b1;
    if (burst == B_INCR && last[AW1-1:12] != first[AW1-1:12]) err = 1'b1;
    return err;
  endfunction

  function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
    return (a >> BYTE_SH) >= ADDR_WIDTH'(MEM_DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a >> BYTE_SH);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // ---------------- write channel ----------------
  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d;
  logic                  werr_q, werr_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  w_last_beat_c, waddr_oor_c, mem_we_c;

  assign w_last_beat_c = (wbeat_q == wlen_q);
  assign waddr_oor_c   = addr_oor(waddr_q);
  assign mem_we_c      = (w_state_q == W_DATA) && axi.wvalid && wready_q && !waddr_oor_c;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wbeat_q   <= '0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wbeat_d   = wbeat_q;
    werr_d    = werr_q;
    case (w_state_q)
      W_IDLE: if (axi.awvalid && awready_q) begin
        waddr_d   = axi.awaddr;
        wlen_d    = axi.awlen;
        wsize_d   = axi.awsize;
        wburst_d  = axi.awburst;
        wbeat_d   = '0;
        werr_d    = cfg_err(axi.awaddr, axi.awlen, axi.awsize, axi.awburst);
        w_state_d = W_DATA;
      end
      // The beat count alone ends the burst; wlast only feeds the error flag.
      W_DATA: if (axi.wvalid && wready_q) begin
        werr_d  = werr_q | waddr_oor_c | (axi.wlast != w_last_beat_c);
        waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
        wbeat_d = wbeat_q + 8'd1;
        if (w_last_beat_c) w_state_d = W_RESP;
      end
      W_RESP: if (bvalid_q && axi.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bresp_d   = (w_state_d == W_RESP && werr_d) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge aclk) begin
    if (mem_we_c) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (axi.wstrb[b]) mem_q[word_idx(waddr_q)][8*b +: 8] <= axi.wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]            rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [2:0]            rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d;
  logic                  rerr_q, rerr_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  r_load_c;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rbeat_q   <= '0;
      rerr_q    <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rbeat_q   <= rbeat_d;
      rerr_q    <= rerr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rbeat_d   = rbeat_q;
    rerr_d    = rerr_q;
    r_load_c  = 1'b0;
    case (r_state_q)
      R_IDLE: if (axi.arvalid && arready_q) begin
        raddr_d   = axi.araddr;
        rlen_d    = axi.arlen;
        rsize_d   = axi.arsize;
        rburst_d  = axi.arburst;
        rbeat_d   = '0;
        rerr_d    = cfg_err(axi.araddr, axi.arlen, axi.arsize, axi.arburst) | addr_oor(axi.araddr);
        r_load_c  = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: if (rvalid_q && axi.rready) begin
        if (rbeat_q == rlen_q) begin
          r_state_d = R_IDLE;
        end else begin
          raddr_d  = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
          rbeat_d  = rbeat_q + 8'd1;
          rerr_d   = rerr_q | addr_oor(raddr_d);
          r_load_c = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Next beat is fetched at the handshake edge, so the old word wins a same-cycle write.
  always_comb begin
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    if (r_load_c) begin
      rlast_d = (rbeat_d == rlen_d);
      rresp_d = rerr_d ? RESP_SLVERR : RESP_OKAY;
      rdata_d = addr_oor(raddr_d) ? '0 : mem_q[word_idx(raddr_d)];
    end else if (r_state_d == R_IDLE) begin
      rlast_d = 1'b0;
    end
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rlast   = rlast_q;
  assign axi.rresp   = rresp_q;
  assign axi.rdata   = rdata_q;
endmodule
